// File: rtl/oam_dma.sv
// oam_dma: sprite-memory DMA engine on the CPU external bus.
// A CPU write of a page number to TRIGGER_ADDR stalls the CPU. The engine
// then copies {page,00}..{page,FF} to OAM_PORT using alternating get/put
// cycles, and releases the bus when the copy is done.
//
// Stall handshake: rdy=1 lets the CPU run; rdy=0 holds it. While
// dma_active=1 the bus mux must take dma_addr/dma_dout/dma_we in place of
// the CPU pins. dma_active is never 1 in a cycle where rdy=1.
module oam_dma #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [ADDR_WIDTH-1:0] OAM_PORT     = 16'h2004
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_dout,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] mem_din,
  output logic                  rdy,
  output logic                  dma_active,
  output logic [ADDR_WIDTH-1:0] dma_addr,
  output logic [DATA_WIDTH-1:0] dma_dout,
  output logic                  dma_we,
  output logic                  dma_done,
  output logic [2:0]            dbg_state,
  output logic [7:0]            dbg_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_GET   = 3'd3,
    S_PUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_page;
  logic [DATA_WIDTH-1:0] w_page_next;
  logic [7:0]            r_idx;
  logic [7:0]            w_idx_next;
  logic                  r_parity;

  logic                  r_rdy;
  logic                  r_active;
  logic                  r_we;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_rdy_next;
  logic                  w_active_next;
  logic                  w_we_next;
  logic                  w_done_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic                  w_trigger;

  // A trigger is only honoured while idle; the page byte comes from cpu_dout.
  assign w_trigger = cpu_we && (cpu_addr == TRIGGER_ADDR);

  // State register plus transfer bookkeeping; parity free-runs out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_page   <= '0;
      r_idx    <= '0;
      r_parity <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_page   <= w_page_next;
      r_idx    <= w_idx_next;
      r_parity <= ~r_parity;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they are
  // registered yet still line up with the state they belong to.
  always_comb begin
    w_state_next  = r_state;
    w_page_next   = r_page;
    w_idx_next    = r_idx;
    w_rdy_next    = 1'b1;
    w_active_next = 1'b0;
    w_we_next     = 1'b0;
    w_done_next   = 1'b0;
    w_addr_next   = '0;

    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_page_next  = cpu_dout;
          w_idx_next   = 8'h00;
          w_state_next = S_HALT;
        end
      end
      // parity=1 now means the next cycle is even, so GET can start there.
      S_HALT:  w_state_next = r_parity ? S_GET : S_ALIGN;
      S_ALIGN: w_state_next = S_GET;
      S_GET:   w_state_next = S_PUT;
      S_PUT: begin
        if (r_idx == 8'hFF) begin
          w_state_next = S_DONE;
        end else begin
          w_idx_next   = r_idx + 8'h01;
          w_state_next = S_GET;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    case (w_state_next)
      S_HALT: begin
        w_rdy_next = 1'b0;
      end
      S_ALIGN, S_GET: begin
        w_rdy_next    = 1'b0;
        w_active_next = 1'b1;
        w_addr_next   = ADDR_WIDTH'({w_page_next, w_idx_next});
      end
      S_PUT: begin
        w_rdy_next    = 1'b0;
        w_active_next = 1'b1;
        w_we_next     = 1'b1;
        w_addr_next   = OAM_PORT;
      end
      S_DONE: begin
        w_done_next = 1'b1;
      end
      default: begin
        w_rdy_next = 1'b1;
      end
    endcase
  end

  // Output registers; the data latch captures mem_din at the end of GET.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdy    <= 1'b1;
      r_active <= 1'b0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_addr   <= '0;
      r_dout   <= '0;
    end else begin
      r_rdy    <= w_rdy_next;
      r_active <= w_active_next;
      r_we     <= w_we_next;
      r_done   <= w_done_next;
      r_addr   <= w_addr_next;
      if (r_state == S_GET) begin
        r_dout <= mem_din;
      end
    end
  end

  assign rdy        = r_rdy;
  assign dma_active = r_active;
  assign dma_we     = r_we;
  assign dma_done   = r_done;
  assign dma_addr   = r_addr;
  assign dma_dout   = r_dout;
  assign dbg_state  = r_state;
  assign dbg_idx    = r_idx;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed bench for oam_dma. A memory model answers reads,
// a negedge monitor tracks bus traffic against an expected-byte queue.
module tb_oam_dma;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic [7:0]  mem_din;
  logic        rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_we;
  logic        dma_done;
  logic [2:0]  dbg_state;
  logic [7:0]  dbg_idx;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_we     (cpu_we),
    .mem_din    (mem_din),
    .rdy        (rdy),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_dout   (dma_dout),
    .dma_we     (dma_we),
    .dma_done   (dma_done),
    .dbg_state  (dbg_state),
    .dbg_idx    (dbg_idx)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference parity: cleared by reset, toggles on every other edge.
  logic tb_par;
  always @(posedge clk) begin
    if (reset) tb_par <= 1'b0;
    else       tb_par <= ~tb_par;
  end

  // ---------------- memory model ----------------
  logic mem_low_mode;
  function automatic logic [7:0] mem_fn(input logic [15:0] a, input logic low);
    if (low) return a[7:0];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction
  assign mem_din = mem_fn(dma_addr, mem_low_mode);

  // ---------------- scoreboard ----------------
  int n_total;
  int n_pass;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  // Monitor counters, cleared by the driver before each scenario.
  int stall_cnt, done_cnt, rd_cnt, put_cnt, zero_cnt;
  int addr_err, par_err, data_err, put_err;
  logic [7:0]  cur_page;
  logic [7:0]  exp_idx;
  logic [15:0] pend_addr;
  logic        pend_par;
  logic [7:0]  pend_data;

  task automatic clear_counters(input logic [7:0] page);
    stall_cnt = 0; done_cnt = 0; rd_cnt = 0; put_cnt = 0; zero_cnt = 0;
    addr_err = 0; par_err = 0; data_err = 0; put_err = 0;
    cur_page = page; exp_idx = 8'h00;
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rdy) stall_cnt++;
    if (dma_done) done_cnt++;
    if (dma_active && dma_addr == 16'h0000) zero_cnt++;
    if (dma_active && !dma_we) begin
      rd_cnt++;
      pend_addr = dma_addr;
      pend_par  = tb_par;
      pend_data = mem_din;
    end
    if (dma_we) begin
      put_cnt++;
      if (!dma_active || rdy || dma_addr != 16'h2004) put_err++;
      if (pend_addr != {cur_page, exp_idx}) addr_err++;
      if (pend_par != 1'b0) par_err++;
      if (dma_dout != pend_data) data_err++;
      if (exp_q.size() == 0) data_err++;
      else if (exp_q.pop_front() != dma_dout) data_err++;
      exp_idx = exp_idx + 8'h01;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_addr = a; cpu_dout = d; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000;
  endtask

  // Issue the trigger so that the HALT cycle is followed by an even
  // (want_even=1) or odd (want_even=0) cycle.
  task automatic trigger_aligned(input logic [7:0] page, input bit want_even);
    @(posedge clk); #1;
    if (tb_par != (want_even ? 1'b0 : 1'b1)) begin
      @(posedge clk); #1;
    end
    cpu_addr = 16'h4014; cpu_dout = page; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 16'h0000;
  endtask

  task automatic load_exp(input logic [7:0] page);
    for (int i = 0; i < 256; i++) exp_q.push_back(mem_fn({page, 8'(i)}, mem_low_mode));
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 1500) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq({tag, "_done_seen"}, (done_cnt > 0) ? 32'd1 : 32'd0, 32'd1);
    idle_cycles(4);
  endtask

  task automatic check_xfer(input string tag, input int exp_stall, input int exp_align);
    check_eq({tag, "_stall"},    stall_cnt, exp_stall);
    check_eq({tag, "_puts"},     put_cnt, 256);
    check_eq({tag, "_align"},    rd_cnt - put_cnt, exp_align);
    check_eq({tag, "_done_cnt"}, done_cnt, 1);
    check_eq({tag, "_addr_err"}, addr_err, 0);
    check_eq({tag, "_par_err"},  par_err, 0);
    check_eq({tag, "_data_err"}, data_err, 0);
    check_eq({tag, "_put_err"},  put_err, 0);
    check_eq({tag, "_zero"},     zero_cnt, 0);
    check_eq({tag, "_q_left"},   exp_q.size(), 0);
    check_eq({tag, "_rdy_end"},  rdy, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    n_total = 0; n_pass = 0;
    reset = 1'b1; cpu_addr = 16'h0000; cpu_dout = 8'h00; cpu_we = 1'b0;
    mem_low_mode = 1'b0;
    clear_counters(8'h00);

    // Reset values.
    idle_cycles(3);
    @(negedge clk);
    check_eq("rst_rdy",    rdy, 1);
    check_eq("rst_active", dma_active, 0);
    check_eq("rst_we",     dma_we, 0);
    check_eq("rst_done",   dma_done, 0);
    check_eq("rst_addr",   dma_addr, 16'h0000);
    check_eq("rst_dout",   dma_dout, 8'h00);
    check_eq("rst_state",  dbg_state, 0);
    check_eq("rst_idx",    dbg_idx, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(2);

    // Page 02, even alignment: 513 stall cycles, no ALIGN.
    clear_counters(8'h02);
    load_exp(8'h02);
    trigger_aligned(8'h02, 1'b1);
    wait_done("even");
    check_xfer("even", 513, 0);

    // Page 02, odd alignment: one ALIGN cycle, 514 stall cycles.
    clear_counters(8'h02);
    load_exp(8'h02);
    trigger_aligned(8'h02, 1'b0);
    wait_done("odd");
    check_xfer("odd", 514, 1);

    // Page FF with low-byte memory: bytes 00..FF, no wrap to 0000.
    mem_low_mode = 1'b1;
    clear_counters(8'hFF);
    load_exp(8'hFF);
    trigger_aligned(8'hFF, 1'b1);
    wait_done("pgff");
    check_xfer("pgff", 513, 0);
    check_eq("pgff_last_get", pend_addr, 16'hFFFF);
    mem_low_mode = 1'b0;

    // Page 03 with a second trigger mid-transfer: ignored.
    clear_counters(8'h03);
    load_exp(8'h03);
    trigger_aligned(8'h03, 1'b1);
    idle_cycles(40);
    cpu_write(16'h4014, 8'h05);
    wait_done("retrig");
    check_xfer("retrig", 513, 0);

    // Reset after PUT #100 aborts the copy.
    clear_counters(8'h04);
    load_exp(8'h04);
    trigger_aligned(8'h04, 1'b1);
    k = 0;
    while (put_cnt < 100 && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("abort_put100", put_cnt, 100);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_rdy",    rdy, 1);
    check_eq("abort_active", dma_active, 0);
    check_eq("abort_we",     dma_we, 0);
    check_eq("abort_idx",    dbg_idx, 0);
    check_eq("abort_state",  dbg_state, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycles(600);
    check_eq("abort_no_more_puts", put_cnt, 100);
    check_eq("abort_no_done",      done_cnt, 0);
    check_eq("abort_rdy_after",    rdy, 1);

    // Non-trigger accesses: 4015 write and 4014 read.
    clear_counters(8'h00);
    cpu_write(16'h4015, 8'h11);
    @(posedge clk); #1;
    cpu_addr = 16'h4014; cpu_dout = 8'h06; cpu_we = 1'b0;
    idle_cycles(3);
    cpu_addr = 16'h0000;
    idle_cycles(20);
    check_eq("notrig_stall",  stall_cnt, 0);
    check_eq("notrig_reads",  rd_cnt, 0);
    check_eq("notrig_rdy",    rdy, 1);

    // Reset coinciding with a trigger write: reset wins.
    clear_counters(8'h00);
    @(posedge clk); #1;
    reset = 1'b1; cpu_addr = 16'h4014; cpu_dout = 8'h07; cpu_we = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000;
    idle_cycles(20);
    check_eq("rsttrig_stall", stall_cnt, 0);
    check_eq("rsttrig_state", dbg_state, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
